// File: rtl/multiword_add_sequencer.sv
// Multi-slice add sequencer: feeds a BIT_WIDTH adder LSB slice first and chains its carry.
// Define START_EDGE_EN to trigger on rising edges of start; the default build triggers on the start level.
module multiword_add_sequencer #(
  parameter int BIT_WIDTH = 4,
  parameter int WORDS     = 4,
  parameter int ADD_LAT   = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [WORDS*BIT_WIDTH-1:0] op_a,
  input  logic [WORDS*BIT_WIDTH-1:0] op_b,
  input  logic                       cin,
  output logic                       busy,
  output logic                       done,
  output logic [WORDS*BIT_WIDTH-1:0] result,
  output logic                       carry_out,
  output logic [BIT_WIDTH-1:0]       add_a,
  output logic [BIT_WIDTH-1:0]       add_b,
  output logic                       add_carry_in,
  input  logic [BIT_WIDTH-1:0]       add_sum,
  input  logic                       add_overflow
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // idx keeps at least one bit so that WORDS=1 still elaborates
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
  localparam logic [1:0]       LAT_MAX  = 2'(ADD_LAT);

  logic [1:0]                 state;
  logic [IDX_W-1:0]           idx;
  logic [1:0]                 lat_cnt;
  logic [WORDS*BIT_WIDTH-1:0] a_reg;
  logic [WORDS*BIT_WIDTH-1:0] b_reg;
  logic                       carry_reg;
  logic                       trigger;

`ifdef START_EDGE_EN
  // start_q resets high so a start held across reset release is not an edge
  logic start_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) start_q <= 1'b1;
    else     start_q <= start;
  end

  assign trigger = start & ~start_q;
`else
  assign trigger = start;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      lat_cnt   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (trigger) begin
            a_reg     <= op_a;
            b_reg     <= op_b;
            carry_reg <= cin;
            idx       <= '0;
            lat_cnt   <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          // the adder output is only trusted on the last cycle of each slice
          if (lat_cnt == LAT_MAX) begin
            result[idx*BIT_WIDTH +: BIT_WIDTH] <= add_sum;
            carry_reg <= add_overflow;
            lat_cnt   <= '0;
            if (idx == LAST_IDX) begin
              carry_out <= add_overflow;
              state     <= S_DONE;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  always_comb begin
    add_a        = '0;
    add_b        = '0;
    add_carry_in = 1'b0;
    if (state == S_RUN) begin
      add_a        = a_reg[idx*BIT_WIDTH +: BIT_WIDTH];
      add_b        = b_reg[idx*BIT_WIDTH +: BIT_WIDTH];
      add_carry_in = carry_reg;
    end
  end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Bench for multiword_add_sequencer: one instance with a combinational adder, one with ADD_LAT=2 and a two-register adder.
module tb_multiword_add_sequencer;

  localparam int BW    = 4;
  localparam int WORDS = 4;
  localparam int DW    = BW * WORDS;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          c;
    logic [DW-1:0] exp_res;
    logic          exp_co;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start0, start2;
  logic [DW-1:0] op_a, op_b;
  logic          cin;

  logic          busy0, done0, carry_out0, add_carry_in0, add_overflow0;
  logic [DW-1:0] result0;
  logic [BW-1:0] add_a0, add_b0, add_sum0;
  logic          busy2, done2, carry_out2, add_carry_in2, add_overflow2;
  logic [DW-1:0] result2;
  logic [BW-1:0] add_a2, add_b2, add_sum2;
  logic [4:0]    pipe1, pipe2;

  int tests    = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multiword_add_sequencer #(.BIT_WIDTH(BW), .WORDS(WORDS), .ADD_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .op_a(op_a), .op_b(op_b), .cin(cin),
    .busy(busy0), .done(done0), .result(result0), .carry_out(carry_out0),
    .add_a(add_a0), .add_b(add_b0), .add_carry_in(add_carry_in0),
    .add_sum(add_sum0), .add_overflow(add_overflow0)
  );

  multiword_add_sequencer #(.BIT_WIDTH(BW), .WORDS(WORDS), .ADD_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .op_a(op_a), .op_b(op_b), .cin(cin),
    .busy(busy2), .done(done2), .result(result2), .carry_out(carry_out2),
    .add_a(add_a2), .add_b(add_b2), .add_carry_in(add_carry_in2),
    .add_sum(add_sum2), .add_overflow(add_overflow2)
  );

  assign {add_overflow0, add_sum0} = 5'(add_a0) + 5'(add_b0) + 5'(add_carry_in0);

  // two-stage adder so that ADD_LAT=2 is really exercised
  always_ff @(posedge clk) begin
    pipe1 <= 5'(add_a2) + 5'(add_b2) + 5'(add_carry_in2);
    pipe2 <= pipe1;
  end
  assign add_sum2      = pipe2[3:0];
  assign add_overflow2 = pipe2[4];

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // carry entering a slice, from plain arithmetic on the low bits of the operands
  function automatic logic expCarryIn(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic c, input int slice);
    logic [DW:0] mask;
    logic [DW:0] s;
    mask = ((DW+1)'(1) << (BW*slice)) - (DW+1)'(1);
    s    = ((DW+1)'(a) & mask) + ((DW+1)'(b) & mask) + (DW+1)'(c);
    return s[BW*slice];
  endfunction

  task automatic applyStimulus(input int sel, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic c,
                               input logic poke, output logic [DW-1:0] res, output logic co,
                               output int busy_cnt, output int done_cnt);
    int  per;
    int  slice;
    logic seen;
    logic bz, dn, aci;
    logic [BW-1:0] aa, ab;
    per = (sel == 0) ? 1 : 3;
    busy_cnt = 0; done_cnt = 0; res = '0; co = 1'b0; seen = 1'b0;
    @(negedge clk);
    op_a = a; op_b = b; cin = c;
    if (sel == 0) start0 = 1'b1; else start2 = 1'b1;
    @(negedge clk);
    for (int k = 0; k < WORDS*per + 6; k++) begin
      start0 = 1'b0; start2 = 1'b0;
      bz  = (sel == 0) ? busy0 : busy2;
      dn  = (sel == 0) ? done0 : done2;
      aa  = (sel == 0) ? add_a0 : add_a2;
      ab  = (sel == 0) ? add_b0 : add_b2;
      aci = (sel == 0) ? add_carry_in0 : add_carry_in2;
      if (bz) begin
        slice = busy_cnt / per;
        if (slice < WORDS) begin
          checkOutput("add_a slice", 32'(aa), 32'(a[slice*BW +: BW]));
          checkOutput("add_b slice", 32'(ab), 32'(b[slice*BW +: BW]));
          checkOutput("add_carry_in slice", 32'(aci), 32'(expCarryIn(a, b, c, slice)));
        end
        busy_cnt++;
        if (poke && busy_cnt == 5) begin
          if (sel == 0) start0 = 1'b1; else start2 = 1'b1;
        end
      end else begin
        checkOutput("add_a idle", 32'(aa), 32'h0);
      end
      if (dn) begin
        done_cnt++;
        if (!seen) begin
          res = (sel == 0) ? result0 : result2;
          co  = (sel == 0) ? carry_out0 : carry_out2;
          seen = 1'b1;
        end
      end
      @(negedge clk);
    end
    start0 = 1'b0; start2 = 1'b0;
    checkOutput("done seen within budget", 32'(seen), 32'h1);
  endtask

  vec_t          vecs[$];
  logic [DW-1:0] res, ra, rb;
  logic          co, rc;
  logic [DW:0]   model;
  int            bc, dc, cyc, last_done;
  int            done_times[$];

  initial begin
    rst = 1'b1; start0 = 1'b0; start2 = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", 32'(busy0), 32'h0);
    checkOutput("reset done", 32'(done0), 32'h0);
    checkOutput("reset result", 32'(result0), 32'h0);
    checkOutput("reset carry_out", 32'(carry_out0), 32'h0);
    checkOutput("reset add_carry_in", 32'(add_carry_in0), 32'h0);
    checkOutput("reset busy lat2", 32'(busy2), 32'h0);
    rst = 1'b0;

    vecs.push_back('{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{16'h1234, 16'h1111, 1'b1, 16'h2346, 1'b0});
    vecs.push_back('{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1});
    vecs.push_back('{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(0, vecs[i].a, vecs[i].b, vecs[i].c, 1'b0, res, co, bc, dc);
      checkOutput("table result", 32'(res), 32'(vecs[i].exp_res));
      checkOutput("table carry_out", 32'(co), 32'(vecs[i].exp_co));
      checkOutput("table busy cycles", 32'(bc), 32'd4);
      checkOutput("table done pulses", 32'(dc), 32'd1);
    end

    // result and carry_out stay put after the done pulse
    repeat (3) @(negedge clk);
    checkOutput("held result", 32'(result0), 32'(vecs[vecs.size()-1].exp_res));

    for (int i = 0; i < 20; i++) begin
      ra = DW'($urandom); rb = DW'($urandom); rc = 1'($urandom);
      model = (DW+1)'(ra) + (DW+1)'(rb) + (DW+1)'(rc);
      applyStimulus(0, ra, rb, rc, 1'b0, res, co, bc, dc);
      checkOutput("random result", 32'(res), 32'(model[DW-1:0]));
      checkOutput("random carry_out", 32'(co), 32'(model[DW]));
    end

    applyStimulus(1, 16'h0F0F, 16'h00F1, 1'b0, 1'b1, res, co, bc, dc);
    checkOutput("lat2 result", 32'(res), 32'h1000);
    checkOutput("lat2 carry_out", 32'(co), 32'h0);
    checkOutput("lat2 busy cycles", 32'(bc), 32'd12);
    checkOutput("lat2 done pulses", 32'(dc), 32'd1);
    repeat (4) @(negedge clk);
    checkOutput("lat2 no queued op", 32'(busy2), 32'h0);

    for (int i = 0; i < 5; i++) begin
      ra = DW'($urandom); rb = DW'($urandom); rc = 1'($urandom);
      model = (DW+1)'(ra) + (DW+1)'(rb) + (DW+1)'(rc);
      applyStimulus(1, ra, rb, rc, 1'b0, res, co, bc, dc);
      checkOutput("lat2 random result", 32'(res), 32'(model[DW-1:0]));
      checkOutput("lat2 random carry_out", 32'(co), 32'(model[DW]));
    end

    // start held high for 20 cycles
    @(negedge clk);
    start0 = 1'b1;
    done_times = {};
    for (cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (done0) done_times.push_back(cyc);
    end
    start0 = 1'b0;
    repeat (10) @(negedge clk);
`ifdef START_EDGE_EN
    checkOutput("held start done count", 32'(done_times.size()), 32'd1);
`else
    checkOutput("held start done count", 32'(done_times.size()), 32'd3);
    last_done = 0;
    for (int i = 1; i < done_times.size(); i++)
      checkOutput("held start done period", 32'(done_times[i] - done_times[i-1]), 32'd6);
`endif

    // reset in the middle of slice 2
    @(negedge clk);
    op_a = 16'h1234; op_b = 16'h4321; cin = 1'b0; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("mid-run add_a slice 2", 32'(add_a0), 32'h2);
    rst = 1'b1;
    #1;
    checkOutput("mid-run reset busy", 32'(busy0), 32'h0);
    checkOutput("mid-run reset done", 32'(done0), 32'h0);
    checkOutput("mid-run reset result", 32'(result0), 32'h0);
    checkOutput("mid-run reset carry_out", 32'(carry_out0), 32'h0);
    checkOutput("mid-run reset add_a", 32'(add_a0), 32'h0);
    checkOutput("mid-run reset add_b", 32'(add_b0), 32'h0);
    checkOutput("mid-run reset add_carry_in", 32'(add_carry_in0), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 16'hABCD, 16'h5433, 1'b0, 1'b0, res, co, bc, dc);
    checkOutput("after reset result", 32'(res), 32'h0000);
    checkOutput("after reset carry_out", 32'(co), 32'h1);

`ifdef START_EDGE_EN
    // a start already high when reset releases is not a rising edge
    @(negedge clk);
    rst = 1'b1; start0 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bc = 0;
    repeat (8) begin
      @(negedge clk);
      if (busy0) bc++;
    end
    checkOutput("start held over reset busy cycles", 32'(bc), 32'd0);
    start0 = 1'b0;
    @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
